// File: rtl/sam_pool_pkg.sv
// Shared types and constants for the SAM pooling stage.
package sam_pool_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int POOL_SIZE_W = 4;
   localparam logic [POOL_SIZE_W-1:0] DEFAULT_POOL_SIZE = POOL_SIZE_W'(1);

   // Buffered result word; the data field matches the default sample width.
   localparam int ENTRY_DATA_W = 32;

   typedef struct packed {
      logic                    last;
      logic [ENTRY_DATA_W-1:0] data;
   } pool_entry_t;

endpackage

// File: rtl/sam_pool_fifo.sv
// Small synchronous FIFO buffering pooled results ahead of the memory writer.
module sam_pool_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Status flags and head word; head reads as zero while empty.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   // Next storage and pointer values; pops on an empty FIFO are dropped.
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage and pointer registers; reset discards all contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/sam_pool.sv
// ReLU + 1-D max-pool stage on the SAM convolution stream, with an output FIFO.
// DATA_W must match the package entry width (ENTRY_DATA_W).
module sam_pool
   import sam_pool_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int POOL_MAX   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Cfg_Load,
   input  logic [POOL_SIZE_W-1:0] Cfg_Pool_Size,
   input  logic                   Cfg_Relu_En,
   input  logic                   In_Valid,
   output logic                   In_Ready,
   input  logic [DATA_W-1:0]      In_Data,
   input  logic                   In_Last,
   output logic                   Out_Valid,
   input  logic                   Out_Ready,
   output logic [DATA_W-1:0]      Out_Data,
   output logic                   Out_Last,
   output logic                   Busy,
   output logic                   Err_Cfg
);

   localparam logic [POOL_SIZE_W-1:0] POOL_MAX_C = POOL_SIZE_W'(POOL_MAX);

   state_e                 state_q, state_d;
   logic [POOL_SIZE_W-1:0] pool_size_q, pool_size_d;
   logic [POOL_SIZE_W-1:0] cnt_q, cnt_d, cnt_new;
   logic                   relu_en_q, relu_en_d;
   logic                   err_cfg_q, err_cfg_d;
   logic                   busy_q, busy_d;
   logic [DATA_W-1:0]      acc_q, acc_d, acc_new, v;
   logic                   accept, close, pop;
   logic                   fifo_full, fifo_empty;
   pool_entry_t            push_entry, head_entry;

   // Output buffer; Out_* come straight from its registered head.
   sam_pool_fifo #(
      .WIDTH ($bits(pool_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .rst   (Rst),
      .push  (close),
      .pop   (pop),
      .din   (push_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head_entry)
   );

   // Handshake and outputs, all from registered state.
   always_comb begin
      In_Ready  = ~fifo_full & (state_q != DRAIN);
      Out_Valid = ~fifo_empty;
      Out_Data  = head_entry.data;
      Out_Last  = head_entry.last;
      Busy      = busy_q;
      Err_Cfg   = err_cfg_q;
      pop       = Out_Ready & ~fifo_empty;
   end

   // ReLU and running max for the current window.
   always_comb begin
      accept = In_Valid & In_Ready;
      v      = (relu_en_q && In_Data[DATA_W-1]) ? '0 : In_Data;
      if (cnt_q == '0) begin
         acc_new = v;
         cnt_new = POOL_SIZE_W'(1);
      end else begin
         acc_new = ($signed(v) > $signed(acc_q)) ? v : acc_q;
         cnt_new = cnt_q + POOL_SIZE_W'(1);
      end
      close           = accept & ((cnt_new == pool_size_q) | In_Last);
      push_entry.last = In_Last;
      push_entry.data = acc_new;
   end

   // FSM, configuration, window counter and busy tracking.
   always_comb begin
      state_d     = state_q;
      pool_size_d = pool_size_q;
      relu_en_d   = relu_en_q;
      err_cfg_d   = err_cfg_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE:    if (accept) state_d = In_Last ? DRAIN : ACCUM;
         ACCUM:   if (accept && In_Last) state_d = DRAIN;
         DRAIN:   if (fifo_empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (Cfg_Load && state_q == IDLE) begin
         relu_en_d = Cfg_Relu_En;
         if (Cfg_Pool_Size == '0 || Cfg_Pool_Size > POOL_MAX_C) begin
            pool_size_d = DEFAULT_POOL_SIZE;
            err_cfg_d   = 1'b1;
         end else begin
            pool_size_d = Cfg_Pool_Size;
         end
      end

      if (accept) begin
         acc_d = acc_new;
         cnt_d = close ? '0 : cnt_new;
      end

      if (accept && state_q == IDLE) busy_d = 1'b1;
      if (pop && head_entry.last)    busy_d = 1'b0;
   end

   // State registers; reset discards any open window.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         pool_size_q <= DEFAULT_POOL_SIZE;
         relu_en_q   <= 1'b0;
         err_cfg_q   <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pool_size_q <= pool_size_d;
         relu_en_q   <= relu_en_d;
         err_cfg_q   <= err_cfg_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_sam_pool.sv
// Self-checking bench for sam_pool: directed scenarios plus randomized frames
// against a window-list reference model.
module tb_sam_pool;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Cfg_Load;
   logic [3:0]  Cfg_Pool_Size;
   logic        Cfg_Relu_En;
   logic        In_Valid;
   logic        In_Ready;
   logic [31:0] In_Data;
   logic        In_Last;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [31:0] Out_Data;
   logic        Out_Last;
   logic        Busy;
   logic        Err_Cfg;

   always #5 Clk = ~Clk;

   sam_pool #(
      .DATA_W     (32),
      .POOL_MAX   (8),
      .FIFO_DEPTH (4)
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Cfg_Load      (Cfg_Load),
      .Cfg_Pool_Size (Cfg_Pool_Size),
      .Cfg_Relu_En   (Cfg_Relu_En),
      .In_Valid      (In_Valid),
      .In_Ready      (In_Ready),
      .In_Data       (In_Data),
      .In_Last       (In_Last),
      .Out_Valid     (Out_Valid),
      .Out_Ready     (Out_Ready),
      .Out_Data      (Out_Data),
      .Out_Last      (Out_Last),
      .Busy          (Busy),
      .Err_Cfg       (Err_Cfg)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: the open window is a list of samples, outputs a list of words.
   int                 m_psize;
   bit                 m_relu, m_err, m_busy, m_drain, m_active;
   logic signed [31:0] win[$];
   logic [32:0]        exp_q[$];
   logic [32:0]        pop_log[$];
   bit                 last_acc;
   int                 ready_mode;   // 0: hold low, 1: hold high, 2: random

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_psize = 1; m_relu = 0; m_err = 0; m_busy = 0; m_drain = 0; m_active = 0;
      win.delete();
      exp_q.delete();
   endtask

   // One clock: check outputs at the falling edge, then advance the model.
   task automatic cycle();
      bit                 exp_ready, exp_valid, acc, pop, was_active;
      int                 occ;
      logic signed [31:0] v, mx;
      if (ready_mode == 2) Out_Ready = 1'($urandom_range(0, 1));
      else                 Out_Ready = (ready_mode == 1);
      @(negedge Clk);
      occ        = exp_q.size();
      was_active = m_active;
      exp_ready  = (occ < 4) && !m_drain;
      exp_valid  = (occ > 0);
      chk("in_ready", In_Ready, exp_ready);
      chk("out_valid", Out_Valid, exp_valid);
      chk("busy", Busy, m_busy);
      chk("err_cfg", Err_Cfg, m_err);
      if (exp_valid) chk("out_head", {Out_Last, Out_Data}, exp_q[0]);
      acc      = In_Valid && exp_ready;
      pop      = exp_valid && Out_Ready;
      last_acc = acc;
      if (pop) begin
         pop_log.push_back({Out_Last, Out_Data});
         if (exp_q[0][32]) m_busy = 0;
         void'(exp_q.pop_front());
      end
      if (acc) begin
         v = In_Data;
         if (m_relu && v < 0) v = 0;
         win.push_back(v);
         m_busy   = 1;
         m_active = 1;
         if (win.size() == m_psize || In_Last) begin
            mx = win[0];
            foreach (win[i]) if (win[i] > mx) mx = win[i];
            exp_q.push_back({In_Last, mx});
            win.delete();
         end
         if (In_Last) m_drain = 1;
      end else if (m_drain && occ == 0) begin
         m_drain  = 0;
         m_active = 0;
      end
      if (Cfg_Load && !was_active) begin
         m_relu = Cfg_Relu_En;
         if (Cfg_Pool_Size == 0 || Cfg_Pool_Size > 8) begin
            m_err   = 1;
            m_psize = 1;
         end else begin
            m_psize = Cfg_Pool_Size;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      int n = 0;
      In_Valid = 1'b1; In_Data = d; In_Last = last;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 300);
      vectors++;
      assert (last_acc) else begin
         miscompares++;
         $error("FAIL accept_timeout: observed no accept, expected accept within %0d cycles", n);
      end
      In_Valid = 1'b0; In_Last = 1'b0; In_Data = '0;
   endtask

   task automatic load_cfg(input logic [3:0] sz, input logic relu);
      Cfg_Load = 1'b1; Cfg_Pool_Size = sz; Cfg_Relu_En = relu;
      cycle();
      Cfg_Load = 1'b0;
   endtask

   task automatic finish_frame();
      int n = 0;
      while ((m_active || m_busy) && n < 300) begin
         cycle();
         n++;
      end
      chk("drain_busy", Busy, 0);
      chk("drain_in_ready", In_Ready, 1);
   endtask

   task automatic chk_pop(input string tag, input int idx, input logic [31:0] d, input logic l);
      logic [32:0] got;
      got = (idx < pop_log.size()) ? pop_log[idx] : 'x;
      chk(tag, got, {l, d});
   endtask

   task automatic apply_reset();
      In_Valid = 1'b0; In_Last = 1'b0; Cfg_Load = 1'b0;
      Rst = 1'b1;
      #2;
      chk("rst_out_valid", Out_Valid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_out_data", Out_Data, 0);
      chk("rst_out_last", Out_Last, 0);
      chk("rst_err_cfg", Err_Cfg, 0);
      chk("rst_in_ready", In_Ready, 1);
      model_reset();
      pop_log.delete();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
   endtask

   initial begin
      int                 len, sz;
      logic [31:0]        d;
      logic [31:0]        vals[3];
      Rst = 1'b1; Cfg_Load = 1'b0; Cfg_Pool_Size = '0; Cfg_Relu_En = 1'b0;
      In_Valid = 1'b0; In_Data = '0; In_Last = 1'b0; Out_Ready = 1'b0;
      ready_mode = 1;
      model_reset();
      @(posedge Clk);
      #1;
      apply_reset();

      // P=2 with ReLU
      load_cfg(4'd2, 1'b1);
      send(-32'sd5, 0); send(32'sd3, 0); send(32'sd7, 0); send(-32'sd2, 1);
      finish_frame();
      chk("t1_count", pop_log.size(), 2);
      chk_pop("t1_out0", 0, 32'sd3, 0);
      chk_pop("t1_out1", 1, 32'sd7, 1);

      // P=3 without ReLU, partial final window
      pop_log.delete();
      load_cfg(4'd3, 1'b0);
      send(-32'sd5, 0); send(-32'sd9, 0); send(-32'sd1, 0); send(32'sd4, 0); send(32'sd2, 1);
      finish_frame();
      chk("t2_count", pop_log.size(), 2);
      chk_pop("t2_out0", 0, -32'sd1, 0);
      chk_pop("t2_out1", 1, 32'sd4, 1);

      // P=1 with backpressure: FIFO fills after four samples
      pop_log.delete();
      load_cfg(4'd1, 1'b0);
      ready_mode = 0;
      send(32'd10, 0); send(32'd11, 0); send(32'd12, 0); send(32'd13, 0);
      In_Valid = 1'b1; In_Data = 32'd14; In_Last = 1'b1;
      repeat (3) cycle();
      chk("t3_full_in_ready", In_Ready, 0);
      ready_mode = 1;
      send(32'd14, 1);
      finish_frame();
      chk("t3_count", pop_log.size(), 5);
      for (int i = 0; i < 5; i++) chk_pop("t3_out", i, 32'(10 + i), (i == 4));

      // Illegal pool sizes 0 and 9
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         load_cfg((k == 0) ? 4'd0 : 4'd9, 1'b0);
         chk("t4_err_cfg", Err_Cfg, 1);
         for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            send(vals[i], (i == 2));
         end
         finish_frame();
         chk("t4_count", pop_log.size(), 3);
         for (int i = 0; i < 3; i++) chk_pop("t4_echo", i, vals[i], (i == 2));
      end

      // Config load mid-frame is ignored
      pop_log.delete();
      load_cfg(4'd4, 1'b0);
      send(32'd1, 0); send(32'd5, 0);
      load_cfg(4'd2, 1'b0);
      send(32'd2, 0); send(32'd3, 0); send(32'd9, 1);
      finish_frame();
      chk("t5_count", pop_log.size(), 2);
      chk_pop("t5_out0", 0, 32'd5, 0);
      chk_pop("t5_out1", 1, 32'd9, 1);
      chk("t5_err_cfg", Err_Cfg, 1);

      // Reset mid-window discards the partial window
      apply_reset();
      load_cfg(4'd4, 1'b0);
      send(32'd8, 0); send(32'd6, 0);
      chk("t6_busy_before", Busy, 1);
      apply_reset();
      load_cfg(4'd4, 1'b0);
      send(32'd1, 0); send(32'd2, 0); send(32'd3, 0); send(32'd4, 1);
      finish_frame();
      chk("t6_count", pop_log.size(), 1);
      chk_pop("t6_out0", 0, 32'd4, 1);

      // Randomized frames with random backpressure, gaps and config noise
      ready_mode = 2;
      for (int f = 0; f < 12; f++) begin
         sz = (f == 11) ? $urandom_range(9, 15) : $urandom_range(1, 8);
         load_cfg(4'(sz), 1'($urandom_range(0, 1)));
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 3) == 0) begin
               Cfg_Load      = ($urandom_range(0, 2) == 0);
               Cfg_Pool_Size = 4'($urandom_range(1, 8));
               Cfg_Relu_En   = 1'($urandom_range(0, 1));
               cycle();
            end
            Cfg_Load = 1'b0;
            d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
            send(d, (i == len - 1));
         end
         finish_frame();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
